// File: rtl/risc_v_mike_imem_loader.sv
// ----------------------------------------------------------------------------
// risc_v_mike_imem_loader
//
// Purpose:
//   Writer side of the instruction memory. A host link (UART or debug bridge)
//   streams bytes in. The first four bytes form a little-endian word count N.
//   The next N groups of four bytes are little-endian instructions. They are
//   written to the instruction memory at byte addresses 0, 4, 8, and so on.
//   The core is held in reset until the whole image has been accepted.
//
// Optional feature (macro RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN):
//   When the macro is defined, a 4-byte little-endian checksum follows the
//   payload. It must equal the mod-2^32 sum of all payload words. A match
//   ends in DONE and a mismatch ends in ERR. When the macro is undefined,
//   there is no checksum phase.
//
// Ports:
//   i_clk            core clock
//   i_rst_n          asynchronous, active-low reset
//   i_load_start     single-cycle pulse that starts a new load session
//   i_rx_valid       byte on i_rx_data is valid
//   i_rx_data        stream byte
//   o_rx_ready       loader accepts a byte this cycle
//   o_imem_wr_en     single-cycle memory write strobe
//   o_imem_wr_addr   word-aligned byte address of the write
//   o_imem_wr_data   instruction word being written
//   o_core_hold      keeps the core/PC in reset (low only in DONE)
//   o_load_done      image loaded successfully (level)
//   o_load_err       session aborted (level)
//   o_words_loaded   number of words written in this session
// ----------------------------------------------------------------------------
module risc_v_mike_imem_loader #(
    parameter  int DATA_MEM_DEPTH = 1024,
    parameter  int ADDR_W         = 32,
    localparam int WCNT_W         = $clog2(DATA_MEM_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_rx_ready,
    output logic              o_imem_wr_en,
    output logic [ADDR_W-1:0] o_imem_wr_addr,
    output logic [31:0]       o_imem_wr_data,
    output logic              o_core_hold,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic [WCNT_W-1:0] o_words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } t_state;

    // The state that follows the last payload word (or an empty header).
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
    localparam t_state S_AFTER_PAYLOAD = S_CHK;
`else
    localparam t_state S_AFTER_PAYLOAD = S_DONE;
`endif

    localparam logic [31:0] DEPTH_32 = 32'(DATA_MEM_DEPTH);

    t_state              r_state;
    t_state              r_state_next;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;       // first three bytes of the current group
    logic [WCNT_W-1:0]   r_count;       // N from the header
    logic [WCNT_W-1:0]   r_words;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
    logic [31:0]         r_sum;
`endif

    logic                w_rx_ready;
    logic                w_accept;
    logic                w_group_end;
    logic                w_restart;
    logic                w_last_word;
    logic [31:0]         w_word;
    logic [WCNT_W-1:0]   w_words_inc;

    // Bytes shift in from the top. After four bytes, the first byte sits in
    // [7:0] and the byte accepted this cycle lands in [31:24].
    assign w_word      = {i_rx_data, r_shift};
    assign w_accept    = i_rx_valid && w_rx_ready;
    assign w_group_end = w_accept && (r_byte_cnt == 2'd3);
    assign w_restart   = i_load_start &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_words_inc = r_words + WCNT_W'(1);
    assign w_last_word = (w_words_inc == r_count);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        w_rx_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load_start) r_state_next = S_HDR;
            end
            S_HDR: begin
                w_rx_ready = 1'b1;
                if (w_group_end) begin
                    if (w_word == 32'd0)          r_state_next = S_AFTER_PAYLOAD;
                    else if (w_word > DEPTH_32)   r_state_next = S_ERR;
                    else                          r_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_rx_ready = 1'b1;
                if (w_group_end && w_last_word) r_state_next = S_AFTER_PAYLOAD;
            end
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
            S_CHK: begin
                w_rx_ready = 1'b1;
                if (w_group_end) r_state_next = (w_word == r_sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (i_load_start) r_state_next = S_HDR;
            end
            default: r_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_count    <= '0;
            r_words    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
            r_sum      <= 32'd0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (w_restart) begin
                r_byte_cnt <= 2'd0;
                r_words    <= '0;
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
                r_sum      <= 32'd0;
`endif
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_shift    <= w_word[31:8];
                if (r_byte_cnt == 2'd3) begin
                    if (r_state == S_HDR) begin
                        // Only used when N is legal, so truncation is harmless.
                        r_count <= w_word[WCNT_W-1:0];
                    end else if (r_state == S_LOAD) begin
                        // The write uses the pre-increment count as its word index.
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= ADDR_W'(r_words) << 2;
                        r_wr_data <= w_word;
                        r_words   <= w_words_inc;
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
                        r_sum     <= r_sum + w_word;
`endif
                    end
                end
            end
        end
    end

    assign o_rx_ready     = w_rx_ready;
    assign o_imem_wr_en   = r_wr_en;
    assign o_imem_wr_addr = r_wr_addr;
    assign o_imem_wr_data = r_wr_data;
    assign o_core_hold    = (r_state != S_DONE);
    assign o_load_done    = (r_state == S_DONE);
    assign o_load_err     = (r_state == S_ERR);
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_risc_v_mike_imem_loader.sv
// ----------------------------------------------------------------------------
// Testbench for risc_v_mike_imem_loader.
// It streams images byte by byte and predicts the outcome of each session
// (DONE or ERR, the write list, and the word count) from the header value
// and the payload words. Every observed write is logged and compared with
// the expected list.
// ----------------------------------------------------------------------------
module tb_risc_v_mike_imem_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int WCNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              core_hold;
    logic              load_done;
    logic              load_err;
    logic [WCNT_W-1:0] words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_words[$];     // payload of the session about to run
    logic [63:0] wr_log[$];      // {addr, data} of every observed write

    risc_v_mike_imem_loader #(
        .DATA_MEM_DEPTH(DEPTH),
        .ADDR_W        (ADDR_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_load_start  (load_start),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .o_rx_ready    (rx_ready),
        .o_imem_wr_en  (wr_en),
        .o_imem_wr_addr(wr_addr),
        .o_imem_wr_data(wr_data),
        .o_core_hold   (core_hold),
        .o_load_done   (load_done),
        .o_load_err    (load_err),
        .o_words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && wr_en === 1'b1) wr_log.push_back({wr_addr, wr_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit exp_wr,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data);
        bit acc;
        if (gaps) begin
            for (int g = 0; g < 4 && $urandom_range(0, 2) == 0; g++) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            // load_start during HDR/LOAD/CHK must be ignored
            if ($urandom_range(0, 7) == 0) load_start = 1'b1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = rx_ready;
            @(negedge clk);
            load_start = 1'b0;
        end
        rx_valid = 1'b0;
        if (!acc) begin
            chk("handshake_timeout", 64'd0, 64'd1);
        end else begin
            chk($sformatf("wr_en_after_byte_%02h", b), 64'(wr_en), 64'(exp_wr));
            if (exp_wr) begin
                chk("wr_addr_latency", 64'(wr_addr), 64'(exp_addr));
                chk("wr_data_latency", 64'(wr_data), 64'(exp_data));
            end
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        wr_log.delete();
        chk("start_hdr_rx_ready", 64'(rx_ready), 64'd1);
        chk("start_core_hold", 64'(core_hold), 64'd1);
        chk("start_load_done", 64'(load_done), 64'd0);
        chk("start_load_err", 64'(load_err), 64'd0);
        chk("start_words", 64'(words_loaded), 64'd0);
    endtask

    task automatic run_session(input logic [31:0] n_hdr, input bit gaps, input bit bad_sum,
                               input string name);
        bit          legal;
        bit          exp_err;
        int          n_exp;
        logic [31:0] sum;
        logic [31:0] cs;
        legal = (n_hdr <= 32'(DEPTH));
        n_exp = legal ? int'(n_hdr) : 0;
        sum   = 32'd0;
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(n_hdr[8*k +: 8], gaps, 1'b0, 32'd0, 32'd0);
        for (int w = 0; w < n_exp; w++) begin
            for (int k = 0; k < 4; k++)
                send_byte(q_words[w][8*k +: 8], gaps, k == 3, 32'(w * 4), q_words[w]);
            sum += q_words[w];
        end
        exp_err = !legal;
`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
        if (legal) begin
            cs = bad_sum ? sum + 32'd1 : sum;
            for (int k = 0; k < 4; k++) send_byte(cs[8*k +: 8], gaps, 1'b0, 32'd0, 32'd0);
            if (bad_sum) exp_err = 1'b1;
        end
`else
        cs = bad_sum ? sum : 32'd0;
`endif
        repeat (2) @(negedge clk);
        chk({name, "_load_done"}, 64'(load_done), 64'(!exp_err));
        chk({name, "_load_err"}, 64'(load_err), 64'(exp_err));
        chk({name, "_core_hold"}, 64'(core_hold), 64'(exp_err));
        chk({name, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({name, "_words_loaded"}, 64'(words_loaded), 64'(n_exp));
        chk({name, "_write_count"}, 64'(wr_log.size()), 64'(n_exp));
        for (int w = 0; w < n_exp && w < wr_log.size(); w++)
            chk($sformatf("%s_write_%0d", name, w), wr_log[w], {32'(w * 4), q_words[w]});
        $display("session %s: N=0x%0h words=%0d done=%0b err=%0b", name, n_hdr,
                 words_loaded, load_done, load_err);
    endtask

    task automatic fill_random(input int n);
        q_words.delete();
        for (int i = 0; i < n; i++) q_words.push_back($urandom);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_core_hold", 64'(core_hold), 64'd1);
        chk("rst_load_done", 64'(load_done), 64'd0);
        chk("rst_load_err", 64'(load_err), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_rx_ready", 64'(rx_ready), 64'd0);

        // Reference 3-word image, back-to-back bytes
        q_words.delete();
        q_words.push_back(32'h00410113);
        q_words.push_back(32'h00100093);
        q_words.push_back(32'h0000006F);
        run_session(32'd3, 1'b0, 1'b0, "img3");

        // Empty image
        q_words.delete();
        run_session(32'd0, 1'b0, 1'b0, "empty");

        // Oversized header, then a random huge one
        run_session(32'(DEPTH + 1), 1'b0, 1'b0, "too_big");
        run_session(32'h8000_0000 | $urandom, 1'b1, 1'b0, "huge");

        // Same reference image with random valid gaps
        q_words.delete();
        q_words.push_back(32'h00410113);
        q_words.push_back(32'h00100093);
        q_words.push_back(32'h0000006F);
        run_session(32'd3, 1'b1, 1'b0, "img3_gaps");

        // Random images
        for (int s = 0; s < 4; s++) begin
            int n;
            n = $urandom_range(1, 8);
            fill_random(n);
            run_session(32'(n), 1'b1, 1'b0, $sformatf("rand%0d", s));
        end

        // Largest legal image
        fill_random(DEPTH);
        run_session(32'(DEPTH), 1'b0, 1'b0, "full");

        // Reset in the middle of a session
        fill_random(4);
        pulse_start();
        for (int k = 0; k < 4; k++) send_byte(8'(k == 0 ? 4 : 0), 1'b0, 1'b0, 32'd0, 32'd0);
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 4; k++)
                send_byte(q_words[w][8*k +: 8], 1'b0, k == 3, 32'(w * 4), q_words[w]);
        send_byte(q_words[2][7:0], 1'b0, 1'b0, 32'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rx_ready", 64'(rx_ready), 64'd0);
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        chk("midrst_core_hold", 64'(core_hold), 64'd1);
        chk("midrst_load_done", 64'(load_done), 64'd0);
        chk("midrst_load_err", 64'(load_err), 64'd0);
        chk("midrst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_random(2);
        run_session(32'd2, 1'b0, 1'b0, "after_rst");

`ifdef RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN
        // One-word image with a good and then a bad checksum
        q_words.delete();
        q_words.push_back(32'h00410113);
        run_session(32'd1, 1'b0, 1'b0, "chk_good");
        run_session(32'd1, 1'b0, 1'b1, "chk_bad");
        fill_random(5);
        run_session(32'd5, 1'b1, 1'b1, "chk_bad_rand");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/risc_v_mike_imem_loader.md
Name: risc_v_mike_imem_loader

Overview:
Writer side of the instruction memory. Receives a byte stream from a host link (UART/debug bridge) and assembles little-endian 32-bit instructions. Writes them sequentially into the instruction memory write port from byte address 0. Holds the core in reset until a complete image has been loaded.

Parameters:
DATA_MEM_DEPTH, 1024, instruction memory depth in 32-bit words; maximum image length.
ADDR_W, 32, width of the byte address driven to memory (t_pc_addr width).

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset
load_start  input  1  single-cycle pulse; begins a new load session
rx_valid  input  1  byte on rx_data is valid
rx_data  input  8  stream byte
rx_ready  output  1  loader accepts a byte this cycle
imem_wr_en  output  1  single-cycle memory write strobe
imem_wr_addr  output  ADDR_W  byte address, always word aligned
imem_wr_data  output  32  instruction word
core_hold  output  1  keep core/PC in reset
load_done  output  1  image loaded successfully; level signal
load_err  output  1  session aborted; level signal
words_loaded  output  $clog2(DATA_MEM_DEPTH+1)  count of words written this session

Behaviour:
- Reset (rst=0, async) values: FSM=IDLE, rx_ready=0, imem_wr_en=0, imem_wr_addr=0, imem_wr_data=0, core_hold=1, load_done=0, load_err=0, words_loaded=0, byte counter=0.
- A byte is accepted only on a cycle with rx_valid && rx_ready. Gaps in rx_valid stall the session without limit.
- Bytes are little-endian: the first byte of each group lands in [7:0], the fourth in [31:24]. A 2-bit byte counter wraps from 3 to 0.
- FSM states:
  - IDLE: rx_ready=0. load_start moves to HDR.
  - HDR: rx_ready=1. Receives a 4-byte word count N. On the 4th byte: N==0 goes to DONE; N>DATA_MEM_DEPTH goes to ERR; otherwise goes to LOAD.
  - LOAD: rx_ready=1. On each 4th byte, the next cycle has imem_wr_en=1, imem_wr_addr=words_loaded<<2 (pre-increment value), and imem_wr_data=the assembled word. words_loaded increments on that same edge. After word N is written, goes to DONE, or to CHK if the feature is enabled.
  - DONE: load_done=1, core_hold=0, rx_ready=0.
  - ERR: load_err=1, core_hold=1, rx_ready=0.
- Write latency: imem_wr_en is registered and asserts exactly 1 cycle after the handshake of the 4th byte. It is never high for 2 consecutive cycles.
- imem_wr_addr and imem_wr_data hold their last values when imem_wr_en=0.
- core_hold=1 in every state except DONE.
- load_start in DONE, ERR or IDLE: go to HDR and clear words_loaded, the byte counter, load_done and load_err. core_hold rises on the next edge.
- load_start in HDR, LOAD or CHK is ignored.
- Reset mid-session returns to IDLE. Words already written remain in memory; the loader does not scrub them.
- Boundary: N==DATA_MEM_DEPTH is legal. The last write goes to address (DATA_MEM_DEPTH-1)<<2 and words_loaded saturates at DATA_MEM_DEPTH.

Optional Feature:
- Macro: RISC_V_MIKE_IMEM_LOADER_CHKSUM_EN.
- Defined:
  - After word N, the FSM enters CHK and accepts 4 more little-endian bytes.
  - These bytes are compared with the running 32-bit sum, mod 2^32, of all payload words. The sum is cleared on load_start.
  - Match goes to DONE; mismatch goes to ERR. No memory write occurs in CHK.
  - For N==0 the checksum is still expected and must be 0.
- Undefined: no CHK state and no sum register. LOAD (or HDR with N==0) goes directly to DONE.

Test Plan:
- Reset released, then load_start, then bytes 03 00 00 00 | 13 01 41 00 | 93 00 10 00 | 6F 00 00 00. Expect writes (addr 0x0, 0x00410113), (0x4, 0x00100093) and (0x8, 0x0000006F), each 1 cycle after its 4th byte. Then load_done=1, core_hold=0, words_loaded=3.
- Header 00 00 00 00 (feature off). Expect DONE with no imem_wr_en pulse. With the feature on, 4 zero checksum bytes are needed first.
- Header with N=DATA_MEM_DEPTH+1 (0x401). Expect ERR: load_err=1, core_hold=1, rx_ready=0, no writes. A following load_start clears load_err and enters HDR.
- Same as the first scenario with rx_valid toggled randomly 1-in-3. Expect identical write contents and addresses.
- Assert rst low after the 2nd word is written. Expect all outputs at reset values immediately. After release and a fresh load_start, writes restart at address 0x0.
- Feature on: 1-word image 13 01 41 00, checksum 13 01 41 00, expect DONE. Repeat with checksum 14 01 41 00, expect ERR after the word at address 0x0 is still written.
